// File: rtl/execute_unit_pkg.sv
// Shared encodings for the execute stage: ALU operations, branch conditions and the IO window base.
package execute_unit_pkg;

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluSll   = 4'd2,
        AluSlt   = 4'd3,
        AluSltu  = 4'd4,
        AluXor   = 4'd5,
        AluSrl   = 4'd6,
        AluSra   = 4'd7,
        AluOr    = 4'd8,
        AluAnd   = 4'd9,
        AluPassB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        BrNever  = 3'd0,
        BrEq     = 3'd1,
        BrNe     = 3'd2,
        BrLt     = 3'd3,
        BrGe     = 3'd4,
        BrLtu    = 3'd5,
        BrGeu    = 3'd6,
        BrAlways = 3'd7
    } branch_cond_e;

    localparam logic [31:0] IoBaseDefault = 32'hFFFF_0000;

    // Everything at or above the base belongs to the IO window.
    function automatic logic in_io_region(input logic [31:0] addr, input logic [31:0] base);
        return addr >= base;
    endfunction

endpackage

// File: rtl/execute_unit_if.sv
// Execute-stage bus: operands and requests from decode, results and strobes back out.
interface execute_unit_if;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic [31:0] cmp_a;
    logic [31:0] cmp_b;
    logic [2:0]  branch_cond;
    logic        branch;
    logic        data_read_en;
    logic        data_write_en;
    logic        mem_read_en;
    logic        mem_write_en;
    logic        io_read_en;
    logic        io_write_en;
    logic        is_io;
    logic        bus_busy;

    modport master (
        output alu_a, alu_b, alu_op, cmp_a, cmp_b, branch_cond, data_read_en, data_write_en,
        input  alu_result, branch, mem_read_en, mem_write_en, io_read_en, io_write_en, is_io,
               bus_busy
    );

    modport slave (
        input  alu_a, alu_b, alu_op, cmp_a, cmp_b, branch_cond, data_read_en, data_write_en,
        output alu_result, branch, mem_read_en, mem_write_en, io_read_en, io_write_en, is_io,
               bus_busy
    );

endinterface

// File: rtl/alu_core.sv
// Combinational 32-bit integer ALU; unassigned opcodes produce zero.
module alu_core
    import execute_unit_pkg::*;
(
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    input  logic [3:0]  alu_op,
    output logic [31:0] alu_result
);

    logic [4:0] shamt;
    logic       lt_signed;
    logic       lt_unsigned;

    assign shamt       = alu_b[4:0];
    assign lt_signed   = $signed(alu_a) < $signed(alu_b);
    assign lt_unsigned = alu_a < alu_b;

    always_comb begin
        alu_result = 32'd0;
        case (alu_op_e'(alu_op))
            AluAdd:   alu_result = alu_a + alu_b;
            AluSub:   alu_result = alu_a - alu_b;
            AluSll:   alu_result = alu_a << shamt;
            AluSlt:   alu_result = {31'd0, lt_signed};
            AluSltu:  alu_result = {31'd0, lt_unsigned};
            AluXor:   alu_result = alu_a ^ alu_b;
            AluSrl:   alu_result = alu_a >> shamt;
            AluSra:   alu_result = $unsigned($signed(alu_a) >>> shamt);
            AluOr:    alu_result = alu_a | alu_b;
            AluAnd:   alu_result = alu_a & alu_b;
            AluPassB: alu_result = alu_b;
            default:  alu_result = 32'd0;
        endcase
    end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: ALU, branch comparator, memory/IO address decode and a one-cycle bus stall.
module execute_unit
    import execute_unit_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IoBaseDefault
) (
    input logic           clk,
    input logic           reset,
    execute_unit_if.slave bus
);

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;

    assign alu_a  = bus.alu_a;
    assign alu_b  = bus.alu_b;
    assign alu_op = bus.alu_op;

    alu_core u_alu_core (
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result)
    );

    assign bus.alu_result = alu_result;

    // Branch comparator
    logic cmp_eq;
    logic cmp_lt;
    logic cmp_ltu;
    logic branch;

    assign cmp_eq  = bus.cmp_a == bus.cmp_b;
    assign cmp_lt  = $signed(bus.cmp_a) < $signed(bus.cmp_b);
    assign cmp_ltu = bus.cmp_a < bus.cmp_b;

    always_comb begin
        branch = 1'b0;
        case (branch_cond_e'(bus.branch_cond))
            BrNever:  branch = 1'b0;
            BrEq:     branch = cmp_eq;
            BrNe:     branch = ~cmp_eq;
            BrLt:     branch = cmp_lt;
            BrGe:     branch = ~cmp_lt;
            BrLtu:    branch = cmp_ltu;
            BrGeu:    branch = ~cmp_ltu;
            BrAlways: branch = 1'b1;
            default:  branch = 1'b0;
        endcase
    end

    assign bus.branch = branch;

    // Address decode
    logic is_io;

    assign is_io            = in_io_region(alu_result, IO_BASE);
    assign bus.is_io        = is_io;
    assign bus.mem_read_en  = bus.data_read_en & ~is_io;
    assign bus.mem_write_en = bus.data_write_en & ~is_io;
    assign bus.io_read_en   = bus.data_read_en & is_io;
    assign bus.io_write_en  = bus.data_write_en & is_io;

    // Stall counter: an access is busy on its first cycle and free on the next.
    logic [2:0] bus_counter_q;
    logic [2:0] bus_counter_d;
    logic       bus_busy;

    always_comb begin
        bus_busy      = (bus.data_read_en | bus.data_write_en) && (bus_counter_q == 3'd0);
        bus_counter_d = 3'd0;
        if (bus_busy) begin
            bus_counter_d = bus_counter_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_counter_q <= 3'd0;
        end else begin
            bus_counter_q <= bus_counter_d;
        end
    end

    assign bus.bus_busy = bus_busy;

endmodule

// File: tb/tb_execute_unit.sv
// Scoreboard bench for execute_unit: directed vectors queue expectations, a monitor drains them.
module tb_execute_unit;

    localparam int KAlu   = 0;
    localparam int KBr    = 1;
    localparam int KIsIo  = 2;
    localparam int KMemRd = 3;
    localparam int KMemWr = 4;
    localparam int KIoRd  = 5;
    localparam int KIoWr  = 6;
    localparam int KBusy  = 7;

    logic clk = 1'b0;
    logic reset;

    execute_unit_if bus_if ();

    execute_unit #(
        .IO_BASE (32'hFFFF_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    event chk_ev;

    string       name_q[$];
    int          kind_q[$];
    logic [31:0] exp_q[$];

    task automatic exp_push(input string name, input int kind, input logic [31:0] v);
        name_q.push_back(name);
        kind_q.push_back(kind);
        exp_q.push_back(v);
    endtask

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            KAlu:    return bus_if.alu_result;
            KBr:     return {31'd0, bus_if.branch};
            KIsIo:   return {31'd0, bus_if.is_io};
            KMemRd:  return {31'd0, bus_if.mem_read_en};
            KMemWr:  return {31'd0, bus_if.mem_write_en};
            KIoRd:   return {31'd0, bus_if.io_read_en};
            KIoWr:   return {31'd0, bus_if.io_write_en};
            default: return {31'd0, bus_if.bus_busy};
        endcase
    endfunction

    // Monitor: compares every queued expectation at the falling edge or on demand.
    initial begin
        forever begin
            @(negedge clk or chk_ev);
            while (name_q.size() > 0) begin
                string       n;
                int          k;
                logic [31:0] e;
                logic [31:0] got;
                n   = name_q.pop_front();
                k   = kind_q.pop_front();
                e   = exp_q.pop_front();
                got = observe(k);
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h at %0t", n, got, e, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic next_step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus_if.alu_a         = 32'd0;
        bus_if.alu_b         = 32'd0;
        bus_if.alu_op        = 4'd0;
        bus_if.cmp_a         = 32'd0;
        bus_if.cmp_b         = 32'd0;
        bus_if.branch_cond   = 3'd0;
        bus_if.data_read_en  = 1'b0;
        bus_if.data_write_en = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } alu_vec_t;

    typedef struct {
        string       name;
        logic [2:0]  cond;
        logic [31:0] a;
        logic [31:0] b;
        logic        exp;
    } br_vec_t;

    alu_vec_t alu_vecs[$];
    br_vec_t  br_vecs[$];

    initial begin
        alu_vecs = '{
            '{"add_wrap",  4'd0,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000},
            '{"sub",       4'd1,  32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFE},
            '{"sll_b33",   4'd2,  32'hFFFF_FFFF, 32'd33,        32'hFFFF_FFFE},
            '{"slt",       4'd3,  32'hFFFF_FFFF, 32'd1,         32'h0000_0001},
            '{"sltu",      4'd4,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000},
            '{"xor",       4'd5,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00},
            '{"srl",       4'd6,  32'hFFFF_FFFF, 32'd4,         32'h0FFF_FFFF},
            '{"sra",       4'd7,  32'hFFFF_FFFF, 32'd4,         32'hFFFF_FFFF},
            '{"sra_pos",   4'd7,  32'h4000_0000, 32'd36,        32'h0400_0000},
            '{"or",        4'd8,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0},
            '{"and",       4'd9,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0},
            '{"pass_b",    4'd10, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000},
            '{"op11_zero", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},
            '{"op15_zero", 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000}
        };
        br_vecs = '{
            '{"br_never",  3'd0, 32'hFFFF_FFFF, 32'd1, 1'b0},
            '{"br_eq_ne",  3'd1, 32'hFFFF_FFFF, 32'd1, 1'b0},
            '{"br_eq_eq",  3'd1, 32'd5,         32'd5, 1'b1},
            '{"br_ne",     3'd2, 32'hFFFF_FFFF, 32'd1, 1'b1},
            '{"br_lt",     3'd3, 32'hFFFF_FFFF, 32'd1, 1'b1},
            '{"br_ge",     3'd4, 32'hFFFF_FFFF, 32'd1, 1'b0},
            '{"br_ltu",    3'd5, 32'hFFFF_FFFF, 32'd1, 1'b0},
            '{"br_geu",    3'd6, 32'hFFFF_FFFF, 32'd1, 1'b1},
            '{"br_always", 3'd7, 32'hFFFF_FFFF, 32'd1, 1'b1}
        };

        reset = 1'b1;
        idle_inputs();
        exp_push("rst_busy",   KBusy,  32'd0);
        exp_push("rst_mem_rd", KMemRd, 32'd0);
        exp_push("rst_mem_wr", KMemWr, 32'd0);
        exp_push("rst_io_rd",  KIoRd,  32'd0);
        exp_push("rst_io_wr",  KIoWr,  32'd0);
        exp_push("rst_branch", KBr,    32'd0);
        exp_push("rst_alu",    KAlu,   32'd0);

        next_step();
        reset = 1'b0;

        foreach (alu_vecs[i]) begin
            next_step();
            bus_if.alu_op = alu_vecs[i].op;
            bus_if.alu_a  = alu_vecs[i].a;
            bus_if.alu_b  = alu_vecs[i].b;
            exp_push(alu_vecs[i].name, KAlu, alu_vecs[i].exp);
        end

        foreach (br_vecs[i]) begin
            next_step();
            bus_if.branch_cond = br_vecs[i].cond;
            bus_if.cmp_a       = br_vecs[i].a;
            bus_if.cmp_b       = br_vecs[i].b;
            exp_push(br_vecs[i].name, KBr, {31'd0, br_vecs[i].exp});
        end

        // Address decode, using PASS-B to place the address on alu_result
        next_step();
        idle_inputs();
        bus_if.alu_op        = 4'd10;
        bus_if.alu_b         = 32'h0000_0100;
        bus_if.data_write_en = 1'b1;
        exp_push("dec_mem_wr",    KMemWr, 32'd1);
        exp_push("dec_mem_is_io", KIsIo,  32'd0);
        exp_push("dec_mem_io_wr", KIoWr,  32'd0);
        exp_push("dec_mem_rd",    KMemRd, 32'd0);

        next_step();
        bus_if.alu_b         = 32'hFFFF_0004;
        bus_if.data_write_en = 1'b0;
        bus_if.data_read_en  = 1'b1;
        exp_push("dec_io_rd",     KIoRd,  32'd1);
        exp_push("dec_io_is_io",  KIsIo,  32'd1);
        exp_push("dec_io_mem_rd", KMemRd, 32'd0);
        exp_push("dec_io_wr",     KIoWr,  32'd0);

        next_step();
        bus_if.alu_b        = 32'hFFFF_0000;
        bus_if.data_read_en = 1'b0;
        exp_push("dec_base_is_io", KIsIo, 32'd1);
        exp_push("dec_idle_io_rd", KIoRd, 32'd0);
        exp_push("dec_idle_busy",  KBusy, 32'd0);

        next_step();
        bus_if.alu_b = 32'hFFFE_FFFF;
        exp_push("dec_below_is_io", KIsIo, 32'd0);

        // Stall sequence: two held reads, then two more
        next_step();
        bus_if.alu_b        = 32'h0000_0200;
        bus_if.data_read_en = 1'b1;
        exp_push("stall_a1", KBusy,  32'd1);
        exp_push("stall_rd", KMemRd, 32'd1);
        next_step();
        exp_push("stall_a2", KBusy, 32'd0);
        next_step();
        exp_push("stall_b1", KBusy, 32'd1);
        next_step();
        exp_push("stall_b2", KBusy, 32'd0);

        // Store stalls the same way
        next_step();
        bus_if.data_read_en  = 1'b0;
        bus_if.data_write_en = 1'b1;
        exp_push("stall_wr1", KBusy, 32'd1);
        next_step();
        exp_push("stall_wr2", KBusy, 32'd0);

        // Reset in the free cycle of a stall restarts it at once
        next_step();
        bus_if.data_write_en = 1'b0;
        bus_if.data_read_en  = 1'b1;
        exp_push("rst_seq_busy", KBusy, 32'd1);
        next_step();
        exp_push("rst_seq_free", KBusy, 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        exp_push("rst_async_busy", KBusy, 32'd1);
        exp_push("rst_async_alu",  KAlu,  32'h0000_0200);
        #1;
        -> chk_ev;

        next_step();
        exp_push("rst_held_busy", KBusy,  32'd1);
        exp_push("rst_held_rd",   KMemRd, 32'd1);
        next_step();
        reset = 1'b0;
        exp_push("post_rst_busy", KBusy, 32'd1);
        next_step();
        exp_push("post_rst_free", KBusy, 32'd0);

        next_step();
        idle_inputs();
        exp_push("idle_busy",   KBusy,  32'd0);
        exp_push("idle_mem_rd", KMemRd, 32'd0);
        exp_push("idle_mem_wr", KMemWr, 32'd0);
        exp_push("idle_io_rd",  KIoRd,  32'd0);
        exp_push("idle_io_wr",  KIoWr,  32'd0);

        @(negedge clk);
        #1;
        if (name_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", name_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
